shift_sub_div: RTL and testbench
================================

SHIFT_SUB_DIV -- requirements
Module: shift_sub_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand width in bits.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port start  input  1  one-cycle pulse that launches a division.
REQ-005 Port in_A  input  WIDTH  unsigned dividend, sampled only when start=1.
REQ-006 Port in_B  input  WIDTH  unsigned divisor, sampled only when start=1.
REQ-007 Port out_data  output  2*WIDTH  result: [2*WIDTH-1:WIDTH] remainder, [WIDTH-1:0] quotient.
REQ-008 Port ready  output  1  high while out_data holds a valid result.
REQ-009 Port div_by_zero  output  1  high with ready when the captured divisor was 0.

Function
REQ-010 The block SHALL implement a restoring shift-subtract divider with states IDLE, BUSY and DONE.
REQ-011 The block SHALL apply this rule when start=1 in any state:
- capture in_A and in_B
- clear the iteration counter
- force ready=0, div_by_zero=0 and out_data=0 on the same edge
REQ-012 Start with divisor nonzero SHALL enter BUSY, with rem=0 (WIDTH+1 bits) and quot=dividend.
REQ-013 Start with divisor zero SHALL go straight to DONE. On the next edge it SHALL set:
- quotient = all ones
- remainder = dividend
- div_by_zero=1, ready=1
REQ-014 Each BUSY cycle SHALL perform one step, in this order:
- shift {rem,quot} left by 1
- if rem >= divisor, rem = rem - divisor and quot[0] = 1, else quot[0] = 0
REQ-015 The counter SHALL run 0..WIDTH-1, one step per cycle. The step at count WIDTH-1 SHALL be the last, and the block SHALL then enter DONE.
REQ-016 In DONE the block SHALL register out_data={rem[WIDTH-1:0],quot} and set ready=1 on the following edge. Latency from the start edge to ready high SHALL be WIDTH+1 cycles (33 at default).
REQ-017 ready, div_by_zero and out_data SHALL hold until the next start or rst. The block SHALL then sit in IDLE.
REQ-018 start during BUSY SHALL abort the current division and restart with the new operands. No partial result SHALL be published.
REQ-019 start on the same edge that ready would rise SHALL take priority, and ready SHALL stay 0.
REQ-020 The remainder SHALL always be < divisor. The identity dividend = quotient*divisor + remainder SHALL hold for every nonzero divisor.
REQ-021 Subtraction SHALL use a WIDTH+1-bit compare so that no carry is lost when rem's top bit is set.

Reset
REQ-022 rst=1 at a clock edge SHALL drive the following, overriding start:
- state=IDLE, count=0, rem=0, quot=0, divisor register=0
- out_data=0, ready=0, div_by_zero=0
REQ-023 rst asserted mid-division SHALL discard the operation. ready SHALL stay 0 until a later start completes.

Structure
REQ-024 A shared package SHALL hold the state encoding (IDLE, BUSY, DONE) and the default width constant 32.
REQ-025 One combinational sub-module, div_step, SHALL implement a single shift-compare-subtract iteration. shift_sub_div SHALL instantiate it once.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- 100/7 -> quotient 14, remainder 2, div_by_zero 0, ready exactly 33 cycles after start.
- 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0. Then 0xFFFFFFFF/0xFFFFFFFF -> quotient 1, remainder 0.
- 5/0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1, ready 1 cycle after start.
- 3/10 -> quotient 0, remainder 3. Then 0x80000000/3 -> quotient 0x2AAAAAAA, remainder 2.
- start 1000/3, then at cycle 10 start 81/9 -> ready only at 33 cycles after the second start, with quotient 9, remainder 0.
- rst at cycle 15 of a division -> all outputs 0, ready stays 0 for 50 cycles with no new start.
REQ-027 A random test of at least 10000 operand pairs SHALL check REQ-020 against a reference model. It SHALL include divisor 0 and divisor > dividend.

Source files
------------

// File: rtl/shift_sub_div_pkg.sv
// Shared definitions for the restoring shift-subtract divider.
package shift_sub_div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sub_div_if.sv
// Request/result bundle of the divider: the master launches, the slave divides.
interface shift_sub_div_if #(
  parameter int WIDTH = shift_sub_div_pkg::DEFAULT_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   in_A;
  logic [WIDTH-1:0]   in_B;
  logic [2*WIDTH-1:0] out_data;
  logic               ready;
  logic               div_by_zero;

  modport master (
    output start, in_A, in_B,
    input  out_data, ready, div_by_zero
  );

  modport slave (
    input  start, in_A, in_B,
    output out_data, ready, div_by_zero
  );

endinterface

// File: rtl/shift_sub_div_step.sv
// One restoring-division iteration: shift {rem,quot} left, then conditionally subtract.
module div_step #(
  parameter int WIDTH = shift_sub_div_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quot_out
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_ext;

  // The shifted remainder can reach 2*divisor-1, so the compare needs the extra bit.
  assign shifted = {rem_in, quot_in} << 1;
  assign rem_sh  = shifted[2*WIDTH:WIDTH];
  assign div_ext = {1'b0, divisor};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    rem_out  = rem_sh;
    quot_out = shifted[WIDTH-1:0];
    if (rem_sh >= div_ext) begin
      rem_out     = rem_sh - div_ext;
      quot_out[0] = 1'b1;
    end
  end

endmodule

// File: rtl/shift_sub_div.sv
// Multi-cycle unsigned divider: WIDTH iterations, result published one cycle later.
module shift_sub_div
  import shift_sub_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic             clk,
  input logic             rst,
  shift_sub_div_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quot;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quot_in (quot),
    .divisor (divisor),
    .rem_out (step_rem),
    .quot_out(step_quot)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A start always wins, including over the DONE->IDLE publish and an ongoing BUSY.
  always_comb begin
    state_next = state;
    if (bus.start) begin
      state_next = (bus.in_B == '0) ? DONE : BUSY;
    end else begin
      unique case (state)
        BUSY:    if (count == LAST_COUNT) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count           <= '0;
      rem             <= '0;
      quot            <= '0;
      divisor         <= '0;
      bus.out_data    <= '0;
      bus.ready       <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else if (bus.start) begin
      count           <= '0;
      rem             <= '0;
      quot            <= bus.in_A;
      divisor         <= bus.in_B;
      bus.out_data    <= '0;
      bus.ready       <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        BUSY: begin
          rem   <= step_rem;
          quot  <= step_quot;
          count <= count + 1'b1;
        end
        DONE: begin
          // A zero divisor skips BUSY, so quot still holds the original dividend.
          if (divisor == '0) begin
            bus.out_data    <= {quot, {WIDTH{1'b1}}};
            bus.div_by_zero <= 1'b1;
          end else begin
            bus.out_data    <= {rem[WIDTH-1:0], quot};
          end
          bus.ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_div.sv
// Directed and randomized checks of shift_sub_div (32-bit and a 4-bit instance).
module tb_shift_sub_div;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_sub_div_if #(.WIDTH(32)) bus  ();
  shift_sub_div_if #(.WIDTH(4))  bus4 ();

  shift_sub_div #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  shift_sub_div #(.WIDTH(4)) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks are entered and left just after a falling edge.
  task automatic pulse32(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.in_A  = a;
    bus.in_B  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_A  = 32'hDEAD_BEEF;
    bus.in_B  = 32'h0BAD_F00D;
  endtask

  // lat = number of rising edges after the start edge before ready was seen high.
  task automatic wait32(output int lat);
    lat = 0;
    while (!bus.ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic div32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat);
    int          lat;
    logic [31:0] eq, er;
    eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
    er = (b == 0) ? a : a % b;
    pulse32(a, b);
    check({tag, " ready_low_after_start"}, 64'(bus.ready), 64'd0);
    wait32(lat);
    if (exp_lat > 0) check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " quotient"},  64'(bus.out_data[31:0]),  64'(eq));
    check({tag, " remainder"}, 64'(bus.out_data[63:32]), 64'(er));
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(b == 0));
  endtask

  task automatic div4(input logic [3:0] a, input logic [3:0] b);
    int       lat;
    logic [3:0] eq, er;
    eq = (b == 0) ? 4'hF : a / b;
    er = (b == 0) ? a : a % b;
    bus4.start = 1'b1;
    bus4.in_A  = a;
    bus4.in_B  = b;
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 0;
    while (!bus4.ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rand4 latency", 64'(lat), (b == 0) ? 64'd1 : 64'd5);
    check("rand4 result", 64'(bus4.out_data), 64'({er, eq}));
    check("rand4 div_by_zero", 64'(bus4.div_by_zero), 64'(b == 0));
  endtask

  initial begin
    int          lat, highs;
    logic [31:0] a, b;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.in_A   = '0;
    bus.in_B   = '0;
    bus4.start = 1'b0;
    bus4.in_A  = '0;
    bus4.in_B  = '0;
    repeat (3) @(negedge clk);
    check("reset out_data", bus.out_data, 64'd0);
    check("reset ready", 64'(bus.ready), 64'd0);
    check("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    div32("100/7", 32'd100, 32'd7, 33);
    repeat (5) @(negedge clk);
    check("hold ready", 64'(bus.ready), 64'd1);
    check("hold out_data", bus.out_data, {32'd2, 32'd14});

    div32("ffffffff/1", 32'hFFFF_FFFF, 32'd1, 33);
    div32("ffffffff/ffffffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    div32("5/0", 32'd5, 32'd0, 1);
    div32("3/10", 32'd3, 32'd10, 33);
    div32("80000000/3", 32'h8000_0000, 32'd3, 33);
    check("80000000/3 const q", 64'(bus.out_data[31:0]), 64'h2AAA_AAAA);

    // Reset while a result is held clears the outputs.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_hold out_data", bus.out_data, 64'd0);
    check("rst_hold ready", 64'(bus.ready), 64'd0);

    // Abort: restart at cycle 10 of a running division.
    pulse32(32'd1000, 32'd3);
    highs = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus.ready) highs++;
    end
    pulse32(32'd81, 32'd9);
    wait32(lat);
    check("abort early_ready", 64'(highs), 64'd0);
    check("abort latency", 64'(lat), 64'd33);
    check("abort result", bus.out_data, {32'd0, 32'd9});

    // Start on the very edge ready would rise takes priority.
    pulse32(32'd100, 32'd7);
    repeat (32) @(negedge clk);
    pulse32(32'd81, 32'd9);
    check("prio ready_low", 64'(bus.ready), 64'd0);
    wait32(lat);
    check("prio latency", 64'(lat), 64'd33);
    check("prio result", bus.out_data, {32'd0, 32'd9});

    // Reset mid-division discards the operation for good.
    pulse32(32'd100, 32'd7);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid out_data", bus.out_data, 64'd0);
    check("rst_mid ready", 64'(bus.ready), 64'd0);
    check("rst_mid div_by_zero", 64'(bus.div_by_zero), 64'd0);
    highs = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.ready) highs++;
    end
    check("rst_mid ready_stays_low", 64'(highs), 64'd0);

    // Random full-width operands, mixing zero, oversized and small divisors.
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      unique case (i % 4)
        0: b = 32'd0;
        1: begin a = $urandom_range(0, 1000); b = $urandom_range(32'hFFFF_FFFF, 1001); end
        2: b = $urandom_range(255, 1);
        default: b = $urandom;
      endcase
      div32("rand32", a, b, 0);
    end

    // Dense random coverage on a narrow instance.
    for (int i = 0; i < 10000; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(15, 0));
      rb = (i % 8 == 0) ? 4'd0 : 4'($urandom_range(15, 0));
      div4(ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
